// File: rtl/cs_enc_ctrl.sv
// cs_enc_ctrl: iterative block-cipher controller. It reuses a single enc_round
// mixer for three passes per round, with 64-bit constants C0/C1 injected before
// passes 2 and 3. It uses subkey 0 as a whitening key at accept time and
// subkey r+1 at the end of round r.
// Optional feature: define CS_ENC_CTRL_ABORT_EN to add an 'abort' input. The
// abort input cancels a block that is in flight or waiting in DONE.

// Single combinational mixing pass: xor-rotate, add-rotate, xor-shift.
module enc_round (
  input  logic [63:0] d_i,
  output logic [63:0] q_o
);
  logic [63:0] a, b;
  assign a   = d_i ^ {d_i[50:0], d_i[63:51]};   // d ^ rotl(d,13)
  assign b   = a + {a[26:0], a[63:27]};         // a + rotl(a,37)
  assign q_o = b ^ (b >> 7);
endmodule

module cs_enc_ctrl #(
  parameter int          NUM_ROUNDS = 8,
  parameter logic [63:0] C0         = 64'h290D61409CEB9E8F,
  parameter logic [63:0] C1         = 64'hB711FA89AE0394E7
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef CS_ENC_CTRL_ABORT_EN
  input  logic        abort,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic [3:0]  key_idx,
  input  logic [63:0] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MIX  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  logic [1:0]  state_q, state_d;
  logic [63:0] st_q, st_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [1:0]  pas_q, pas_d;

  logic [63:0] mix_in, mix_out, pass_const;

  // One shared mixer; its input is the state with the pass constant folded in.
  enc_round u_round (
    .d_i (mix_in),
    .q_o (mix_out)
  );

  // Constant schedule per pass: none, C0, C1.
  always_comb begin
    pass_const = 64'd0;
    case (pas_q)
      2'd1:    pass_const = C0;
      2'd2:    pass_const = C1;
      default: pass_const = 64'd0;
    endcase
  end

  assign mix_in   = st_q ^ pass_const;
  assign out_data = st_q;

  // Next-state, counter and handshake logic.
  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    rnd_d     = rnd_q;
    pas_d     = pas_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    key_idx   = 4'd0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d    = in_data ^ key_in;   // whitening with subkey 0
          rnd_d   = 4'd0;
          pas_d   = 2'd0;
          state_d = S_MIX;
        end
      end
      S_MIX: begin
        key_idx = rnd_q + 4'd1;
        if (pas_q != 2'd2) begin
          st_d  = mix_out;
          pas_d = pas_q + 2'd1;
        end else begin
          st_d  = mix_out ^ key_in;     // round key closes the round
          pas_d = 2'd0;
          if (rnd_q == LAST_RND) state_d = S_DONE;
          else                   rnd_d   = rnd_q + 4'd1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        // Return to IDLE only; the next accept is a cycle later (no bypass).
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CS_ENC_CTRL_ABORT_EN
    // Abort drops an in-flight or finished block; it has no effect in IDLE.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      st_d    = 64'd0;
      rnd_d   = 4'd0;
      pas_d   = 2'd0;
    end
`endif
  end

  // State registers; reset clears everything so out_data reads zero at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= 64'd0;
      rnd_q   <= 4'd0;
      pas_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      pas_q   <= pas_d;
    end
  end

endmodule

// File: doc/cs_enc_ctrl.md
CS_ENC_CTRL -- requirements
Module: cs_enc_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 8, meaning the number of cipher rounds per block (legal range 1..15).
REQ-002 SHALL have parameter C0, default 64'h290D61409CEB9E8F, meaning the constant XORed before the 2nd mix pass.
REQ-003 SHALL have parameter C1, default 64'hB711FA89AE0394E7, meaning the constant XORed before the 3rd mix pass.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning the reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  meaning a plaintext block is offered.
REQ-007 SHALL have port in_ready  output  1  meaning the controller accepts a block this cycle.
REQ-008 SHALL have port in_data  input  64  meaning the plaintext block.
REQ-009 SHALL have port key_idx  output  4  meaning the index of the subkey requested from the external key schedule.
REQ-010 SHALL have port key_in  input  64  meaning subkey[key_idx], combinational from the key store, valid in the same cycle.
REQ-011 SHALL have port out_valid  output  1  meaning a ciphertext block is presented.
REQ-012 SHALL have port out_ready  input  1  meaning the consumer takes the block this cycle.
REQ-013 SHALL have port out_data  output  64  meaning the ciphertext block.

Function
REQ-014 SHALL instantiate exactly one enc_round instance and reuse it for all passes; no other mixing logic.
REQ-015 SHALL implement states IDLE, MIX, DONE in a 64-bit state register st, with round counter rnd (0..NUM_ROUNDS-1) and pass counter pas (0..2).
REQ-016 In IDLE: in_ready=1, key_idx=0; on in_valid: st <= in_data ^ key_in, rnd <= 0, pas <= 0, go to MIX.
REQ-017 In MIX: in_ready=0; enc_round input = st ^ {0, C0, C1}[pas]; key_idx = rnd+1.
REQ-018 In MIX with pas<2: st <= enc_round output, pas <= pas+1.
REQ-019 In MIX with pas=2: st <= enc_round output ^ key_in, pas <= 0; if rnd=NUM_ROUNDS-1 go to DONE, else rnd <= rnd+1.
REQ-020 Latency: out_valid SHALL rise exactly 3*NUM_ROUNDS cycles after the accepting edge (24 at default); subkeys 0..NUM_ROUNDS each used once, in order.
REQ-021 In DONE: out_valid=1, out_data=st, in_ready=0, key_idx=0; st held stable until out_valid&out_ready, then go to IDLE.
REQ-022 SHALL NOT accept a new block in the same cycle as the DONE handshake; the next accept is earliest one cycle later (no bypass).
REQ-023 out_data SHALL equal st in all states (undefined content only qualified by out_valid).
REQ-024 in_valid while not in IDLE SHALL be ignored with no state change.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, st=0, rnd=0, pas=0, giving in_ready=1, out_valid=0, out_data=0, key_idx=0.
REQ-026 Reset asserted mid-MIX or in DONE SHALL discard the block with no out_valid pulse; first accept possible on the first edge with rst_n high.

Configuration
REQ-027 Macro CS_ENC_CTRL_ABORT_EN defined: SHALL add port abort input 1; abort=1 on an edge in MIX or DONE returns to IDLE, clears st/rnd/pas, emits no out_valid; abort in IDLE is ignored and takes priority over nothing else (in_valid in IDLE still accepted).
REQ-028 Macro CS_ENC_CTRL_ABORT_EN undefined: SHALL have no abort port; behaviour exactly REQ-014..REQ-026.

Verification
REQ-029 Reset release, in_valid=1, in_data=0, all subkeys 0 -> in_ready falls next cycle, out_valid rises exactly 24 cycles after accept, out_data equals software model (24 passes of enc_round with C0/C1 schedule).
REQ-030 in_data=64'h0123456789ABCDEF, subkey[i]=64'h1111111111111111*i -> key_idx sequence 0,1(x3),2(x3)..8(x3); out_data matches model.
REQ-031 out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-032 in_valid pulsed during MIX with different data -> ignored; result matches the first block only.
REQ-033 rst_n low at cycle 12 of MIX -> outputs per REQ-025 immediately; no out_valid; new block after release completes correctly in 24 cycles.
REQ-034 With CS_ENC_CTRL_ABORT_EN: abort=1 at pass 5 -> IDLE next cycle, no out_valid; back-to-back new block gives correct result.
